// File: rtl/if_stage.sv
// Instruction-fetch stage: the program counter plus the IF/ID pipeline register.
// Optional macro IF_REDIRECT_CNT_EN adds a free-running count of taken redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        npc_op,
    input  logic [31:0] npc_change,
    input  logic        stall,
    input  logic [31:0] irom_inst,
    output logic [31:0] irom_adr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_idex,
`ifdef IF_REDIRECT_CNT_EN
    output logic [31:0] redirect_cnt,
`endif
    output logic        misalign_err
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] if_id_pc_reg;
    logic [31:0] if_id_inst_reg;
    logic        if_id_valid_reg;
    logic        misalign_err_reg;
    logic        unused_npc_bit;

    // Bit 0 of the target is dropped along with bit 1; only bit 1 is flagged.
    assign unused_npc_bit = npc_change[0];

    // A redirect outranks a stall so a taken branch is never lost to a hold.
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (npc_op) begin
            pc_next = {npc_change[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            if_id_pc_reg    <= 32'd0;
            if_id_inst_reg  <= NOP_INST;
            if_id_valid_reg <= 1'b0;
        end else if (npc_op) begin
            if_id_pc_reg    <= 32'd0;
            if_id_inst_reg  <= NOP_INST;
            if_id_valid_reg <= 1'b0;
        end else if (!stall) begin
            if_id_pc_reg    <= pc_reg;
            if_id_inst_reg  <= irom_inst;
            if_id_valid_reg <= 1'b1;
        end
    end

    // Sticky until reset so software-visible fault status survives later redirects.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            misalign_err_reg <= 1'b0;
        end else if (npc_op && npc_change[1]) begin
            misalign_err_reg <= 1'b1;
        end
    end

`ifdef IF_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_reg;

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            redirect_cnt_reg <= 32'd0;
        end else if (npc_op) begin
            redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
`endif

    assign irom_adr     = pc_reg;
    assign if_id_pc     = if_id_pc_reg;
    assign if_id_pc4    = if_id_pc_reg + 32'd4;
    assign if_id_inst   = if_id_inst_reg;
    assign if_id_valid  = if_id_valid_reg;
    assign flush_idex   = npc_op;
    assign misalign_err = misalign_err_reg;

endmodule
